// File: rtl/button_reader.sv
// Push-button front end: two-flop synchronizer, debounce filter and
// short/long press classifier with one-cycle event pulses.
module button_reader #(
    parameter int CLOCK_SPEED       = 12000000,
    parameter int DEBOUNCE_CYCLES   = CLOCK_SPEED / 100,
    parameter int LONG_PRESS_CYCLES = CLOCK_SPEED / 2,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 2);
    localparam logic          PIN_IDLE  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } state_e;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sync_pressed;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_level_q, db_level_d;
    logic          rise, fall;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          short_q, short_d;
    logic          long_q, long_d;

    // Synchronizer, debounce counter and debounced level registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= PIN_IDLE;
            sync2_q    <= PIN_IDLE;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES differing samples
    always_comb begin
        sync1_d      = btn_i;
        sync2_d      = sync1_q;
        sync_pressed = sync2_q ^ ACTIVE_LOW;
        db_cnt_d     = '0;
        db_level_d   = db_level_q;
        if (sync_pressed != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync_pressed;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
        rise = db_level_d & ~db_level_q;
        fall = ~db_level_d & db_level_q;
    end

    // Press classifier state and hold counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: release always beats the long-press threshold
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (rise) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = LONG;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Event pulses decoded from the current state and debounce edges
    always_comb begin
        pressed_d = db_level_d;
        press_d   = (state_q == IDLE) & rise;
        release_d = (state_q != IDLE) & fall;
        short_d   = (state_q == DOWN) & fall;
        long_d    = (state_q == DOWN) & ~fall & (hold_q == HOLD_LAST);
    end

    // Registered outputs so every pulse lands on the debounce edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign short_o   = short_q;
    assign long_o    = long_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: sample-window reference model checked every
// cycle, plus directed scenarios with literal event timings.
module tb_button_reader;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam bit AL = 1'b1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_i = 1'b1;
    logic pressed_o, press_o, release_o, short_o, long_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int rec_press = -1, rec_release = -1, rec_short = -1, rec_long = -1;
    int n_press = 0, n_release = 0, n_short = 0, n_long = 0, n_hi = 0;

    button_reader #(
        .CLOCK_SPEED(12000000),
        .DEBOUNCE_CYCLES(DB),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_i(btn_i),
        .pressed_o(pressed_o),
        .press_o(press_o),
        .release_o(release_o),
        .short_o(short_o),
        .long_o(long_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: the level flips once the last DB synchronized
    // samples, all taken since the previous flip, disagree with it.
    int  m_cyc = 0;
    int  m_press_cyc = -1000;
    bit  m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_long_done = 1'b0;
    bit  samp_q[$];
    bit  e_pressed, e_press, e_release, e_short, e_long;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1        <= 1'b0;
            m_s2        <= 1'b0;
            m_lvl       <= 1'b0;
            m_long_done <= 1'b0;
            samp_q.delete();
            e_pressed   <= 1'b0;
            e_press     <= 1'b0;
            e_release   <= 1'b0;
            e_short     <= 1'b0;
            e_long      <= 1'b0;
        end else begin
            automatic int c = m_cyc + 1;
            automatic bit all_diff = 1'b1;
            automatic bit flip;
            automatic bit at_long;
            m_cyc <= c;
            samp_q.push_back(m_s2);
            if (samp_q.size() > DB) void'(samp_q.pop_front());
            foreach (samp_q[j]) if (samp_q[j] == m_lvl) all_diff = 1'b0;
            flip = all_diff && (samp_q.size() == DB);
            if (flip) samp_q.delete();
            at_long = !flip && m_lvl && !m_long_done &&
                      (c == m_press_cyc + LP - 1);
            m_s1      <= btn_i ^ AL;
            m_s2      <= m_s1;
            m_lvl     <= m_lvl ^ flip;
            e_pressed <= m_lvl ^ flip;
            e_press   <= flip && !m_lvl;
            e_release <= flip && m_lvl;
            e_short   <= flip && m_lvl && !m_long_done;
            e_long    <= at_long;
            if (flip && !m_lvl) begin
                m_press_cyc <= c;
                m_long_done <= 1'b0;
            end else if (at_long) begin
                m_long_done <= 1'b1;
            end
        end
    end

    // Per-cycle comparison and event recording
    always @(negedge clk) begin
        chk("pressed_o", pressed_o, e_pressed);
        chk("press_o", press_o, e_press);
        chk("release_o", release_o, e_release);
        chk("short_o", short_o, e_short);
        chk("long_o", long_o, e_long);
        if (press_o)   begin rec_press   = cyc; n_press++;   end
        if (release_o) begin rec_release = cyc; n_release++; end
        if (short_o)   begin rec_short   = cyc; n_short++;   end
        if (long_o)    begin rec_long    = cyc; n_long++;    end
        if (pressed_o) n_hi++;
    end

    initial begin
        int t0, r, sv_rel, sv_short, sv_long, sv_press;
        tick(3);
        reset_n = 1'b1;

        // Idle pin
        tick(100);
        chk("idle_press_cnt", n_press, 0);
        chk("idle_release_cnt", n_release, 0);
        chk("idle_long_cnt", n_long, 0);
        chk("idle_pressed_hi", n_hi, 0);

        // Short press of 12 cycles
        t0 = cyc;
        btn_i = 1'b0;
        tick(12);
        btn_i = 1'b1;
        tick(20);
        chk("short_press_cyc", rec_press, t0 + 6);
        chk("short_release_cyc", rec_release, t0 + 18);
        chk("short_short_cyc", rec_short, t0 + 18);
        chk("short_long_cnt", n_long, 0);

        // Bounce
        sv_press = n_press;
        for (int i = 0; i < 15; i++) begin
            btn_i = ~btn_i;
            tick(2);
        end
        btn_i = 1'b1;
        tick(20);
        chk("bounce_press_cnt", n_press, sv_press);

        // Long hold of 60 cycles
        sv_short = n_short;
        t0 = cyc;
        btn_i = 1'b0;
        tick(60);
        btn_i = 1'b1;
        tick(20);
        chk("long_press_cyc", rec_press, t0 + 6);
        chk("long_long_cyc", rec_long, t0 + 25);
        chk("long_release_cyc", rec_release, t0 + 66);
        chk("long_short_cnt", n_short, sv_short);

        // Release landing on the long threshold
        sv_long = n_long;
        t0 = cyc;
        btn_i = 1'b0;
        tick(19);
        btn_i = 1'b1;
        tick(20);
        chk("tie_press_cyc", rec_press, t0 + 6);
        chk("tie_short_cyc", rec_short, t0 + 25);
        chk("tie_release_cyc", rec_release, t0 + 25);
        chk("tie_long_cnt", n_long, sv_long);

        // Reset mid-press
        t0 = cyc;
        btn_i = 1'b0;
        tick(11);
        chk("rst_pre_pressed", pressed_o, 1);
        #1 reset_n = 1'b0;
        #1 chk("rst_async_pressed", pressed_o, 0);
        sv_rel = n_release;
        sv_short = n_short;
        tick(3);
        reset_n = 1'b1;
        r = cyc;
        tick(10);
        chk("rst_repress_cyc", rec_press, r + 6);
        chk("rst_release_cnt", n_release, sv_rel);
        chk("rst_short_cnt", n_short, sv_short);
        btn_i = 1'b1;
        tick(20);
        chk("rst_final_short", rec_short, r + 16);

        // Random stimulus with occasional resets
        for (int i = 0; i < 400; i++) begin
            automatic int len = ($urandom_range(0, 3) == 0) ?
                                $urandom_range(15, 45) :
                                $urandom_range(1, 8);
            btn_i = ~btn_i;
            tick(len);
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
        end
        btn_i = 1'b1;
        tick(30);
        chk("final_pressed", pressed_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
